// File: rtl/mem_pkg.sv
// Shared constants for the data-memory subsystem: geometry and requester port IDs.
package mem_pkg;
  localparam int DATA_W   = 64;
  localparam int DEPTH    = 256;
  localparam int IDX_W    = $clog2(DEPTH);
  localparam int PORT_MEM = 0;
  localparam int PORT_AUX = 1;
endpackage

// File: rtl/data_memory.sv
// Single-port data memory, DEPTH x DATA_W, registered read, write-first not needed
// because the arbiter never issues a read and a write in the same cycle.
module data_memory #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [IDX_W-1:0]  address,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] read_data_reg;

  always_ff @(posedge clk) begin
    if (mem_write) begin
      mem[address] <= write_data;
    end
    if (mem_read) begin
      read_data_reg <= mem[address];
    end
  end

  assign read_data = read_data_reg;
endmodule

// File: rtl/rr_arbiter2.sv
// Two-request round-robin arbiter; the loser of a grant gets precedence next time.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic prio_reg;
  logic prio_next;

  always_comb begin
    gnt       = 2'b00;
    prio_next = prio_reg;
    if (req[0] && (!req[1] || !prio_reg)) begin
      gnt[0] = 1'b1;
    end else if (req[1]) begin
      gnt[1] = 1'b1;
    end
    if (gnt[0]) begin
      prio_next = 1'b1;
    end else if (gnt[1]) begin
      prio_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_reg <= 1'b0;
    end else begin
      prio_reg <= prio_next;
    end
  end
endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data-memory port between the MEM stage (port 0) and a secondary master
// (port 1): round-robin grant, range check, per-port registered read responses.
module dmem_arbiter #(
  parameter int DATA_W = mem_pkg::DATA_W,
  parameter int DEPTH  = mem_pkg::DEPTH,
  parameter int IDX_W  = mem_pkg::IDX_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [DATA_W-1:0] addr0,
  input  logic [DATA_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              err0,
  output logic              err1,
  output logic              stall0
);
  localparam int PM = mem_pkg::PORT_MEM;
  localparam int PA = mem_pkg::PORT_AUX;

  logic [1:0]        req;
  logic [1:0]        gnt;
  logic [1:0]        we;
  logic [DATA_W-1:0] addr  [2];
  logic [DATA_W-1:0] wdata [2];
  logic [DATA_W-1:0] rdata [2];
  logic [1:0]        rvalid_vec;
  logic [1:0]        err_vec;

  logic              sel;
  logic              busy;
  logic              we_sel;
  logic [DATA_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;
  logic              in_range;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_q;

  // No grants while reset is high, so nothing can be committed to memory during reset.
  assign req       = {req1, req0} & {2{~reset}};
  assign we        = {we1, we0};
  assign addr[PM]  = addr0;
  assign addr[PA]  = addr1;
  assign wdata[PM] = wdata0;
  assign wdata[PA] = wdata1;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .gnt   (gnt)
  );

  assign sel       = gnt[PA];
  assign busy      = |gnt;
  assign we_sel    = we[sel];
  assign addr_sel  = addr[sel];
  assign wdata_sel = wdata[sel];
  assign in_range  = (addr_sel[DATA_W-1:IDX_W] == '0);
  assign mem_read  = busy & ~we_sel & in_range;
  assign mem_write = busy & we_sel & in_range;

  data_memory #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_mem (
    .clk        (clk),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .address    (addr_sel[IDX_W-1:0]),
    .write_data (wdata_sel),
    .read_data  (mem_q)
  );

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic              rvalid_reg;
      logic              err_reg;
      logic [DATA_W-1:0] hold_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          rvalid_reg <= 1'b0;
          err_reg    <= 1'b0;
          hold_reg   <= '0;
        end else begin
          rvalid_reg <= gnt[gi] & ~we[gi];
          err_reg    <= gnt[gi] & ~in_range;
          if (rvalid_vec[gi]) begin
            hold_reg <= rdata[gi];
          end
        end
      end

      // Masking with reset kills a response whose grant edge was just before reset.
      assign rvalid_vec[gi] = rvalid_reg & ~reset;
      assign err_vec[gi]    = err_reg & ~reset;
      // The memory's read register is shared; each port keeps its last response in hold_reg.
      assign rdata[gi] = rvalid_vec[gi] ? (err_reg ? '0 : mem_q) : hold_reg;
    end
  endgenerate

  assign gnt0    = gnt[PM];
  assign gnt1    = gnt[PA];
  assign stall0  = req0 & ~gnt[PM];
  assign rvalid0 = rvalid_vec[PM];
  assign rvalid1 = rvalid_vec[PA];
  assign err0    = err_vec[PM];
  assign err1    = err_vec[PA];
  assign rdata0  = rdata[PM];
  assign rdata1  = rdata[PA];
endmodule

// File: tb/tb_dmem_arbiter.sv
// Table-driven bench for dmem_arbiter with a response scoreboard and a reference memory.
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [63:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1, stall0;
  logic [63:0] rdata0, rdata1;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk     (clk),
    .reset   (reset),
    .req0    (req0),
    .req1    (req1),
    .we0     (we0),
    .we1     (we1),
    .addr0   (addr0),
    .addr1   (addr1),
    .wdata0  (wdata0),
    .wdata1  (wdata1),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .rvalid0 (rvalid0),
    .rvalid1 (rvalid1),
    .rdata0  (rdata0),
    .rdata1  (rdata1),
    .err0    (err0),
    .err1    (err1),
    .stall0  (stall0)
  );

  typedef struct {
    logic        req0, we0;
    logic [63:0] addr0, wdata0;
    logic        req1, we1;
    logic [63:0] addr1, wdata1;
    logic        g0, g1;
  } vec_t;

  typedef struct {
    int          port;
    logic        rvalid;
    logic        err;
    logic [63:0] data;
  } rsp_t;

  vec_t        tbl [17];
  rsp_t        q [$];
  logic [63:0] model [256];
  logic [63:0] last_rdata [2];
  int          total = 0;
  int          bad = 0;

  function automatic vec_t mk(logic r0, logic w0, logic [63:0] a0, logic [63:0] d0,
                              logic r1, logic w1, logic [63:0] a1, logic [63:0] d1,
                              logic g0, logic g1);
    vec_t v;
    v.req0 = r0; v.we0 = w0; v.addr0 = a0; v.wdata0 = d0;
    v.req1 = r1; v.we1 = w1; v.addr1 = a1; v.wdata1 = d1;
    v.g0 = g0; v.g1 = g1;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic apply(vec_t v);
    req0 = v.req0; we0 = v.we0; addr0 = v.addr0; wdata0 = v.wdata0;
    req1 = v.req1; we1 = v.we1; addr1 = v.addr1; wdata1 = v.wdata1;
  endtask

  task automatic expect_access(int p, logic we, logic [63:0] a, logic [63:0] d);
    rsp_t e;
    logic inr;
    logic [63:0] a_hi;
    a_hi = a >> 8;
    inr = (a_hi == 64'd0);
    e.port = p;
    if (!we) begin
      e.rvalid = 1'b1;
      e.err    = !inr;
      e.data   = inr ? model[a[7:0]] : 64'd0;
      q.push_back(e);
    end else if (inr) begin
      model[a[7:0]] = d;
    end else begin
      e.rvalid = 1'b0;
      e.err    = 1'b1;
      e.data   = 64'd0;
      q.push_back(e);
    end
  endtask

  task automatic check_response();
    rsp_t        e;
    logic [1:0]  rv;
    logic [1:0]  er;
    logic [63:0] rd [2];
    int          o;
    rv = {rvalid1, rvalid0};
    er = {err1, err0};
    rd[0] = rdata0;
    rd[1] = rdata1;
    if (q.size() > 0) begin
      e = q.pop_front();
      o = 1 - e.port;
      chk($sformatf("rvalid%0d", e.port), {63'd0, rv[e.port]}, {63'd0, e.rvalid});
      chk($sformatf("err%0d", e.port), {63'd0, er[e.port]}, {63'd0, e.err});
      if (e.rvalid) begin
        chk($sformatf("rdata%0d", e.port), rd[e.port], e.data);
        last_rdata[e.port] = e.data;
      end else begin
        chk($sformatf("rdata%0d_hold", e.port), rd[e.port], last_rdata[e.port]);
      end
      chk($sformatf("idle_rv_err%0d", o), {62'd0, rv[o], er[o]}, 64'd0);
      chk($sformatf("rdata%0d_hold", o), rd[o], last_rdata[o]);
    end else begin
      chk("no_response", {60'd0, rvalid0, rvalid1, err0, err1}, 64'd0);
      chk("rdata0_hold", rdata0, last_rdata[0]);
      chk("rdata1_hold", rdata1, last_rdata[1]);
    end
  endtask

  task automatic run_row(int idx, vec_t v);
    check_response();
    apply(v);
    #1;
    chk($sformatf("gnt0_row%0d", idx), {63'd0, gnt0}, {63'd0, v.g0});
    chk($sformatf("gnt1_row%0d", idx), {63'd0, gnt1}, {63'd0, v.g1});
    chk($sformatf("stall0_row%0d", idx), {63'd0, stall0}, {63'd0, v.req0 & ~v.g0});
    $display("row %0d: req=%b%b gnt=%b%b stall0=%b", idx, v.req0, v.req1, gnt0, gnt1, stall0);
    if (v.g0) expect_access(0, v.we0, v.addr0, v.wdata0);
    if (v.g1) expect_access(1, v.we1, v.addr1, v.wdata1);
  endtask

  initial begin
    vec_t idle;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    //           r0 w0 addr0               wdata0        r1 w1 addr1    wdata1  g0 g1
    tbl[0]  = mk(1, 1, 64'd1,              64'h11,       1, 1, 64'd2,   64'h22, 1, 0);
    tbl[1]  = mk(0, 0, 64'd0,              64'd0,        1, 1, 64'd2,   64'h22, 0, 1);
    tbl[2]  = mk(1, 1, 64'd5,              64'hDEADBEEF, 0, 0, 64'd0,   64'd0,  1, 0);
    tbl[3]  = mk(1, 0, 64'd5,              64'd0,        0, 0, 64'd0,   64'd0,  1, 0);
    tbl[4]  = mk(0, 0, 64'd0,              64'd0,        1, 0, 64'd2,   64'd0,  0, 1);
    tbl[5]  = mk(1, 0, 64'd1,              64'd0,        1, 0, 64'd2,   64'd0,  1, 0);
    tbl[6]  = mk(1, 0, 64'd1,              64'd0,        1, 0, 64'd2,   64'd0,  0, 1);
    tbl[7]  = mk(1, 0, 64'd1,              64'd0,        1, 0, 64'd2,   64'd0,  1, 0);
    tbl[8]  = mk(1, 0, 64'd1,              64'd0,        1, 0, 64'd2,   64'd0,  0, 1);
    tbl[9]  = mk(0, 0, 64'd0,              64'd0,        1, 0, 64'h100, 64'd0,  0, 1);
    tbl[10] = mk(0, 0, 64'd0,              64'd0,        1, 1, 64'h105, 64'h7,  0, 1);
    tbl[11] = mk(0, 0, 64'd0,              64'd0,        1, 0, 64'd5,   64'd0,  0, 1);
    tbl[12] = mk(1, 1, 64'd9,              64'hAA,       1, 0, 64'd9,   64'd0,  1, 0);
    tbl[13] = mk(0, 0, 64'd0,              64'd0,        1, 0, 64'd9,   64'd0,  0, 1);
    tbl[14] = idle;
    tbl[15] = mk(1, 0, 64'h1_0000_0003,    64'd0,        0, 0, 64'd0,   64'd0,  1, 0);
    tbl[16] = idle;

    last_rdata[0] = 64'd0;
    last_rdata[1] = 64'd0;

    // Reset held two cycles with both ports requesting.
    reset = 1'b1;
    apply(tbl[0]);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_rvalid", {62'd0, rvalid0, rvalid1}, 64'd0);
    chk("reset_err", {62'd0, err0, err1}, 64'd0);
    chk("reset_rdata0", rdata0, 64'd0);
    chk("reset_rdata1", rdata1, 64'd0);
    reset = 1'b0;
    run_row(0, tbl[0]);

    for (int i = 1; i < 17; i++) begin
      @(negedge clk);
      run_row(i, tbl[i]);
    end

    // Reset in the cycle after a port 0 read grant must swallow the response and clear prio.
    @(negedge clk);
    run_row(17, mk(1, 0, 64'd1, 64'd0, 0, 0, 64'd0, 64'd0, 1, 0));
    @(negedge clk);
    reset = 1'b1;
    apply(idle);
    #1;
    chk("rst_mid_rvalid0_n1", {63'd0, rvalid0}, 64'd0);
    chk("rst_mid_err0_n1", {63'd0, err0}, 64'd0);
    q.delete();
    $display("reset mid-operation: rvalid0=%b", rvalid0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_mid_rvalid0_n2", {63'd0, rvalid0}, 64'd0);
    chk("rst_mid_rdata0", rdata0, 64'd0);
    chk("rst_mid_rdata1", rdata1, 64'd0);
    last_rdata[0] = 64'd0;
    last_rdata[1] = 64'd0;
    @(negedge clk);
    run_row(18, mk(1, 0, 64'd1, 64'd0, 1, 0, 64'd2, 64'd0, 1, 0));
    @(negedge clk);
    run_row(19, idle);
    @(negedge clk);
    run_row(20, idle);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
